// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_pkg;

    localparam int unsigned DMEM_DEPTH = 64;
    localparam int unsigned DMEM_DW    = 32;
    localparam int unsigned DMEM_AW    = 32;

    // Requester port indices
    localparam int unsigned P0 = 0;
    localparam int unsigned P1 = 1;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    // Word-aligned and word index below depth
    function automatic logic addr_legal(input logic [DMEM_AW-1:0] addr,
                                        input logic [DMEM_AW-1:0] depth);
        return (addr[1:0] == 2'b00) && ({2'b00, addr[DMEM_AW-1:2]} < depth);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter.
interface dmem_arbiter_if
    import dmem_pkg::*;
#(
    parameter int unsigned DW = DMEM_DW
);
    logic               req;
    logic               we;
    logic               lock;
    logic [DMEM_AW-1:0] addr;
    logic [DW-1:0]      wdata;
    logic               gnt;
    logic               rvalid;
    logic               err;
    logic [DW-1:0]      rdata;

    modport master (
        output req, we, lock, addr, wdata,
        input  gnt, rvalid, err, rdata
    );

    modport slave (
        input  req, we, lock, addr, wdata,
        output gnt, rvalid, err, rdata
    );
endinterface

// File: rtl/dmem_rr_pick.sv
// Two-way winner picker: round-robin on a tie, or port 0 when fixed is set.
module dmem_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       fixed,
    output logic [1:0] grant
);

    // Sole requester wins; a tie goes to the port that did not win last
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (fixed || last) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the CPU LSU (port 0) and a DMA/debug loader (port 1).
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH      = DMEM_DEPTH,
    parameter int unsigned DW         = DMEM_DW,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic               clk,
    input  logic               reset_n,
    dmem_arbiter_if.slave      m0,
    dmem_arbiter_if.slave      m1,
    output logic               mem_we,
    output logic [DMEM_AW-1:0] mem_a,
    output logic [DW-1:0]      mem_wd,
    input  logic [DW-1:0]      mem_rd
);

    arb_state_t         state;
    logic               last_grant;
    logic [1:0]         pick_gnt;
    logic [1:0]         gnt;
    logic               sel_p1;
    logic               sel_we;
    logic [DMEM_AW-1:0] sel_addr;
    logic [DW-1:0]      sel_wdata;
    logic               sel_legal;
    logic               rd_ok;
    logic               acc_err;

    dmem_rr_pick u_pick (
        .req   ({m1.req, m0.req}),
        .last  (last_grant),
        .fixed (FIXED_PRIO),
        .grant (pick_gnt)
    );

    // Grant decode: free arbitration in ARB, owner-only while locked, nothing in reset
    always_comb begin
        gnt = 2'b00;
        if (reset_n) begin
            case (state)
                ARB:     gnt = pick_gnt;
                LOCK0:   gnt = {1'b0, m0.req};
                LOCK1:   gnt = {m1.req, 1'b0};
                default: gnt = 2'b00;
            endcase
        end
    end

    assign m0.gnt = gnt[P0];
    assign m1.gnt = gnt[P1];

    // Route the granted port onto the memory bus
    always_comb begin
        sel_p1    = gnt[P1];
        sel_we    = sel_p1 ? m1.we    : m0.we;
        sel_addr  = sel_p1 ? m1.addr  : m0.addr;
        sel_wdata = sel_p1 ? m1.wdata : m0.wdata;
        sel_legal = addr_legal(sel_addr, DMEM_AW'(DEPTH));
        rd_ok     = (|gnt) && !sel_we && sel_legal;
        acc_err   = (|gnt) && !sel_legal;
        mem_we    = (|gnt) && sel_we && sel_legal;
        mem_a     = sel_addr;
        mem_wd    = sel_wdata;
    end

    // Arbiter FSM and round-robin history
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ARB;
            last_grant <= 1'b1;
        end else begin
            if (|gnt) begin
                last_grant <= gnt[P1];
            end
            case (state)
                ARB: begin
                    if (gnt[P0] && m0.lock) begin
                        state <= LOCK0;
                    end else if (gnt[P1] && m1.lock) begin
                        state <= LOCK1;
                    end
                end
                LOCK0: begin
                    if (!m0.lock) begin
                        state <= ARB;
                    end
                end
                LOCK1: begin
                    if (!m1.lock) begin
                        state <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

    // Per-port response registers: one-cycle rvalid/err pulses, rdata held until next read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m0.rvalid <= 1'b0;
            m0.err    <= 1'b0;
            m0.rdata  <= '0;
            m1.rvalid <= 1'b0;
            m1.err    <= 1'b0;
            m1.rdata  <= '0;
        end else begin
            m0.rvalid <= gnt[P0] && rd_ok;
            m0.err    <= gnt[P0] && acc_err;
            m1.rvalid <= gnt[P1] && rd_ok;
            m1.err    <= gnt[P1] && acc_err;
            if (gnt[P0] && rd_ok) begin
                m0.rdata <= mem_rd;
            end
            if (gnt[P1] && rd_ok) begin
                m1.rdata <= mem_rd;
            end
        end
    end

endmodule
